// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch: owns the PC, drives the synchronous imem and loads the IF/ID register.
// Latency: a word reaches IF/ID two edges after its address is presented; a redirect costs one bubble.
// Backpressure: stall holds PC, IF/ID and the imem output (clken low); redirect overrides stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int          ADDR_WIDTH = 30
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic                  imem_clken,
    input  logic [31:0]           imem_q,
    output logic [31:0]           if_id_instr,
    output logic [31:0]           if_id_pc,
    output logic                  if_id_valid,
    output logic                  misaligned_fault,
    output logic [31:0]           fetch_count
);
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED, ST_FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_inc;
    logic [29:0] next_word;
    logic        redirect_ok;
    logic        advance;

    assign pc_inc      = pc_q + 32'd4;
    assign redirect_ok = (redirect_pc[1:0] == 2'b00);
    assign advance     = (state_q == ST_RUN) && !redirect_valid && !halt && !stall;

    // Address of the word that will be on imem_q after the next edge.
    always_comb begin
        next_word = pc_inc[31:2];
        if (state_q == ST_BOOT) begin
            next_word = RESET_PC[31:2];
        end else if (redirect_valid) begin
            next_word = redirect_pc[31:2];
        end else if (stall || (state_q == ST_HALTED) || (state_q == ST_FAULT)) begin
            next_word = pc_q[31:2];
        end
    end

    always_comb begin
        imem_clken = 1'b0;
        case (state_q)
            ST_BOOT:           imem_clken = 1'b1;
            ST_RUN, ST_HALTED: imem_clken = redirect_valid ||
                                            ((state_q == ST_RUN) && !stall && !halt);
            default:           imem_clken = 1'b0;
        endcase
    end

    assign imem_address = next_word[ADDR_WIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        instr_d       = instr_q;
        id_pc_d       = id_pc_q;
        id_valid_d    = id_valid_q;
        fault_d       = fault_q;
        count_d       = count_q;
        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                pc_d          = RESET_PC;
                fetch_valid_d = 1'b1;
            end
            ST_RUN, ST_HALTED: begin
                if (redirect_valid) begin
                    // Flush IF/ID so nothing stale reaches decode, even under stall.
                    id_valid_d = 1'b0;
                    instr_d    = NOP_INSTR;
                    if (redirect_ok) begin
                        state_d       = ST_RUN;
                        pc_d          = redirect_pc;
                        fetch_valid_d = 1'b1;
                    end else begin
                        state_d       = ST_FAULT;
                        fault_d       = 1'b1;
                        fetch_valid_d = 1'b0;
                    end
                end else if ((state_q == ST_RUN) && halt) begin
                    state_d       = ST_HALTED;
                    id_valid_d    = 1'b0;
                    instr_d       = NOP_INSTR;
                    fetch_valid_d = 1'b0;
                end else if (advance) begin
                    instr_d    = imem_q;
                    id_pc_d    = pc_q;
                    id_valid_d = fetch_valid_q;
                    pc_d       = pc_inc;
                    if (fetch_valid_q) begin
                        count_d = count_q + 32'd1;
                    end
                end
            end
            default: begin
                id_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
            id_pc_q       <= 32'd0;
            id_valid_q    <= 1'b0;
            fault_q       <= 1'b0;
            count_q       <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
            id_pc_q       <= id_pc_d;
            id_valid_q    <= id_valid_d;
            fault_q       <= fault_d;
            count_q       <= count_d;
        end
    end

    assign if_id_instr      = instr_q;
    assign if_id_pc         = id_pc_q;
    assign if_id_valid      = id_valid_q;
    assign misaligned_fault = fault_q;
    assign fetch_count      = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Bench for fetch_unit: randomized stall/redirect/halt against a stream-level model and a PC scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] RST_PC0 = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n = 1'b1;
    logic        stall = 1'b0, redirect_valid = 1'b0, halt = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    logic [29:0] imem_address, w_address;
    logic        imem_clken, w_clken;
    logic [31:0] imem_q = 32'd0, w_q = 32'd0;
    logic [31:0] if_id_instr, if_id_pc, fetch_count;
    logic        if_id_valid, misaligned_fault;
    logic [31:0] w_instr, w_pc, w_count;
    logic        w_valid, w_fault;

    fetch_unit dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .imem_address(imem_address),
        .imem_clken(imem_clken), .imem_q(imem_q), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .misaligned_fault(misaligned_fault), .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
        .clock(clock), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .imem_address(w_address),
        .imem_clken(w_clken), .imem_q(w_q), .if_id_instr(w_instr),
        .if_id_pc(w_pc), .if_id_valid(w_valid),
        .misaligned_fault(w_fault), .fetch_count(w_count)
    );

    function automatic logic [31:0] memf(input logic [29:0] a);
        return 32'hA000_0000 + {2'b00, a};
    endfunction

    always @(posedge clock) if (imem_clken) imem_q <= memf(imem_address);
    always @(posedge clock) if (w_clken) w_q <= memf(w_address);

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream-level reference: a fetch stream starts at the boot PC or a redirect target and
    // delivers consecutive words, one per un-stalled cycle, until halt, redirect or fault.
    bit          m_boot, m_fault, m_halted, m_primed;
    logic [31:0] m_pc;
    logic        exp_valid, exp_fault;
    logic [31:0] exp_count;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        m_boot = 1; m_fault = 0; m_halted = 0; m_primed = 0; m_pc = RST_PC0;
        exp_valid = 0; exp_fault = 0; exp_count = 0;
        exp_q.delete();
    endtask

    task automatic step(input logic s, input logic rv, input logic [31:0] rp, input logic h);
        logic        ck;
        logic [31:0] nxt;
        @(negedge clock);
        stall = s; redirect_valid = rv; redirect_pc = rp; halt = h;
        ck = 1'b0;
        nxt = m_pc;
        if (m_boot) begin
            ck = 1'b1; nxt = RST_PC0; m_boot = 0; m_primed = 1; m_pc = RST_PC0;
        end else if (m_fault) begin
            ck = 1'b0;
        end else if (rv) begin
            ck = 1'b1; nxt = rp; exp_valid = 1'b0;
            if (rp[1:0] != 2'b00) begin
                m_fault = 1; exp_fault = 1'b1; m_primed = 0;
            end else begin
                m_halted = 0; m_primed = 1; m_pc = rp;
            end
        end else if (m_halted) begin
            ck = 1'b0;
        end else if (h) begin
            m_halted = 1; m_primed = 0; exp_valid = 1'b0;
        end else if (!s) begin
            ck = 1'b1; nxt = m_pc + 32'd4; exp_valid = m_primed;
            if (m_primed) begin
                exp_q.push_back(m_pc);
                exp_count = exp_count + 32'd1;
            end
            m_pc = m_pc + 32'd4;
        end
        #1;
        check("imem_clken", 32'(imem_clken), 32'(ck));
        if (ck) check("imem_address", 32'(imem_address), {2'b00, nxt[31:2]});
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        stall = 0; redirect_valid = 0; halt = 0; redirect_pc = 0;
        model_reset();
        #1;
        check("rst_instr", if_id_instr, NOP);
        check("rst_pc", if_id_pc, 32'd0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_fault", 32'(misaligned_fault), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_clken", 32'(imem_clken), 32'd1);
        check("rst_address", 32'(imem_address), {2'b00, RST_PC0[31:2]});
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    // Monitor: per-cycle status checks plus in-order scoreboard of delivered instructions.
    logic [31:0] prev_pc = 32'd0, prev_instr = 32'd0, mon_e;
    logic        prev_valid = 1'b0;
    int          edge_n = 0;
    bit          wrap_chk = 1;

    always @(posedge clock) begin
        #1;
        if (!reset_n) begin
            edge_n = 0;
        end else begin
            edge_n++;
            check("if_id_valid", 32'(if_id_valid), 32'(exp_valid));
            check("fetch_count", fetch_count, exp_count);
            check("misaligned_fault", 32'(misaligned_fault), 32'(exp_fault));
            if (if_id_valid) begin
                if (!prev_valid || if_id_pc != prev_pc) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_instr actual pc %h required none", if_id_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("if_id_pc", if_id_pc, mon_e);
                        check("if_id_instr", if_id_instr, memf(mon_e[31:2]));
                    end
                end else begin
                    check("hold_instr", if_id_instr, prev_instr);
                end
            end
            if (wrap_chk && edge_n >= 2 && edge_n <= 4) begin
                check("wrap_pc", w_pc, WRAP_PC + 32'(4 * (edge_n - 2)));
                check("wrap_count", w_count, 32'(edge_n - 1));
                check("wrap_valid", 32'(w_valid), 32'd1);
                if (edge_n == 4) wrap_chk = 0;
            end
        end
        prev_valid = if_id_valid;
        prev_pc    = if_id_pc;
        prev_instr = if_id_instr;
    end

    initial begin
        logic        s, rv, h;
        logic [31:0] rp;
        model_reset();
        do_reset();
        repeat (4) step(0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 1, 32'h40, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 32'h80, 0);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        repeat (5) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 1, 32'h20, 0);
        repeat (4) step(0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            s  = ($urandom % 100) < 30;
            rv = ($urandom % 100) < 8;
            h  = ($urandom % 100) < 4;
            rp = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if (m_halted && ($urandom % 4) == 0) rv = 1'b1;
            step(s, rv, rp, h);
        end

        step(0, 1, 32'h22, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom % 2), 1'($urandom % 2), {26'd0, 6'($urandom_range(0, 15)), 2'b00},
                 1'($urandom % 2));
        end

        do_reset();
        repeat (8) step(0, 0, 0, 0);
        do_reset();
        repeat (5) step(0, 0, 0, 0);

        @(posedge clock);
        #3;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
